// File: rtl/branch_predict_resolve.sv
// Decode-stage branch resolution with a tagged 2-bit bimodal predictor.
// Lookup: if_pc -> pred_taken/pred_target. Resolve: id_* and operands
// (register or forwarded) -> branch_taken, mispredict, redirect_pc.
// Optional BRANCH_STATS_EN adds branch_cnt/mispredict_cnt outputs.
module branch_predict_resolve #(
    parameter int DATA_W    = 32,
    parameter int BHT_DEPTH = 64,
    parameter int FWD_SRCS  = 3,
    localparam int SEL_W    = $clog2(FWD_SRCS + 1)
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          if_pc,
    output logic                       pred_taken,
    output logic [DATA_W-1:0]          pred_target,
    input  logic                       id_valid,
    input  logic                       id_stall,
    input  logic [DATA_W-1:0]          id_pc,
    input  logic                       id_pred_taken,
    input  logic [2:0]                 branch_type,
    input  logic [15:0]                id_imm,
    input  logic [DATA_W-1:0]          reg_a,
    input  logic [DATA_W-1:0]          reg_b,
    input  logic [FWD_SRCS*DATA_W-1:0] fwd_data,
    input  logic [SEL_W-1:0]           src_sel_a,
    input  logic [SEL_W-1:0]           src_sel_b,
    output logic [DATA_W-1:0]          cmp_a,
    output logic [DATA_W-1:0]          cmp_b,
    output logic                       branch_taken,
    output logic                       mispredict,
    output logic [DATA_W-1:0]          redirect_pc
`ifdef BRANCH_STATS_EN
    ,
    output logic [31:0]                branch_cnt,
    output logic [31:0]                mispredict_cnt
`endif
);

    localparam int IDX_W = $clog2(BHT_DEPTH);
    localparam int TAG_W = DATA_W - IDX_W - 2;

    localparam logic [2:0] BT_BEQ  = 3'b001;
    localparam logic [2:0] BT_BNE  = 3'b010;
    localparam logic [2:0] BT_BLEZ = 3'b011;
    localparam logic [2:0] BT_BGTZ = 3'b100;
    localparam logic [2:0] BT_BLTZ = 3'b101;
    localparam logic [2:0] BT_BGEZ = 3'b110;

    // Operand select: 0 and any value with no matching slot pick the register.
    always_comb begin
        cmp_a = reg_a;
        cmp_b = reg_b;
        for (int k = 0; k < FWD_SRCS; k++) begin
            if (src_sel_a == SEL_W'(k + 1)) cmp_a = fwd_data[k*DATA_W +: DATA_W];
            if (src_sel_b == SEL_W'(k + 1)) cmp_b = fwd_data[k*DATA_W +: DATA_W];
        end
    end

    logic a_neg;
    logic a_zero;
    assign a_neg  = cmp_a[DATA_W-1];
    assign a_zero = (cmp_a == '0);

    always_comb begin
        branch_taken = 1'b0;
        case (branch_type)
            BT_BEQ:  branch_taken = (cmp_a == cmp_b);
            BT_BNE:  branch_taken = (cmp_a != cmp_b);
            BT_BLEZ: branch_taken = a_neg | a_zero;
            BT_BGTZ: branch_taken = ~a_neg & ~a_zero;
            BT_BLTZ: branch_taken = a_neg;
            BT_BGEZ: branch_taken = ~a_neg;
            default: branch_taken = 1'b0;
        endcase
    end

    logic is_branch;
    logic qualify;
    assign is_branch = (branch_type != 3'b000) && (branch_type != 3'b111);
    assign qualify   = id_valid & ~id_stall & is_branch;
    assign mispredict = qualify & (branch_taken ^ id_pred_taken);

    logic [DATA_W-1:0] imm_ext;
    logic [DATA_W-1:0] id_seq;
    logic [DATA_W-1:0] tgt_raw;
    logic [DATA_W-1:0] target;
    assign imm_ext = {{(DATA_W-18){id_imm[15]}}, id_imm, 2'b00};
    assign id_seq  = id_pc + DATA_W'(4);
    assign tgt_raw = id_seq + imm_ext;
    // Branch targets never cross into the other half of the address space.
    assign target  = {id_pc[DATA_W-1], tgt_raw[DATA_W-2:0]};
    assign redirect_pc = branch_taken ? target : id_seq;

    // Predictor table
    logic [BHT_DEPTH-1:0] valid_q, valid_d;
    logic [TAG_W-1:0]     tag_q [BHT_DEPTH];
    logic [TAG_W-1:0]     tag_d [BHT_DEPTH];
    logic [DATA_W-1:0]    tgt_q [BHT_DEPTH];
    logic [DATA_W-1:0]    tgt_d [BHT_DEPTH];
    logic [1:0]           cnt_q [BHT_DEPTH];
    logic [1:0]           cnt_d [BHT_DEPTH];

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    assign if_idx = if_pc[IDX_W+1:2];
    assign if_tag = if_pc[DATA_W-1:IDX_W+2];
    assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);

    // Reads come from registered state, so a same-cycle update is not visible.
    assign pred_taken  = if_hit & cnt_q[if_idx][1];
    assign pred_target = pred_taken ? tgt_q[if_idx] : if_pc + DATA_W'(4);

    logic [IDX_W-1:0] id_idx;
    logic [TAG_W-1:0] id_tag;
    logic             id_hit;
    logic [1:0]       cnt_cur;
    logic [1:0]       cnt_new;
    assign id_idx  = id_pc[IDX_W+1:2];
    assign id_tag  = id_pc[DATA_W-1:IDX_W+2];
    assign id_hit  = valid_q[id_idx] && (tag_q[id_idx] == id_tag);
    assign cnt_cur = cnt_q[id_idx];

    // A new allocation starts weakly biased toward the observed outcome.
    always_comb begin
        cnt_new = cnt_cur;
        if (!id_hit) begin
            cnt_new = branch_taken ? 2'b10 : 2'b01;
        end else if (branch_taken) begin
            cnt_new = (cnt_cur == 2'b11) ? 2'b11 : cnt_cur + 2'd1;
        end else begin
            cnt_new = (cnt_cur == 2'b00) ? 2'b00 : cnt_cur - 2'd1;
        end
    end

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        tgt_d   = tgt_q;
        cnt_d   = cnt_q;
        if (qualify) begin
            valid_d[id_idx] = 1'b1;
            tag_d[id_idx]   = id_tag;
            tgt_d[id_idx]   = target;
            cnt_d[id_idx]   = cnt_new;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < BHT_DEPTH; i++) begin
                tag_q[i] <= '0;
                tgt_q[i] <= '0;
                cnt_q[i] <= 2'b01;
            end
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            tgt_q   <= tgt_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] branch_cnt_q, branch_cnt_d;
    logic [31:0] mispredict_cnt_q, mispredict_cnt_d;

    always_comb begin
        branch_cnt_d     = branch_cnt_q + {31'd0, qualify};
        mispredict_cnt_d = mispredict_cnt_q + {31'd0, mispredict};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed scoreboard bench for branch_predict_resolve.
// Stimulus queues expected values; a negedge monitor pops and compares.
module tb_branch_predict_resolve;

    localparam int DATA_W    = 32;
    localparam int BHT_DEPTH = 64;
    localparam int FWD_SRCS  = 3;
    localparam int SEL_W     = $clog2(FWD_SRCS + 1);

    localparam int S_PT  = 0;
    localparam int S_PTG = 1;
    localparam int S_MP  = 2;
    localparam int S_RPC = 3;
    localparam int S_BT  = 4;
    localparam int S_CA  = 5;
    localparam int S_CB  = 6;
    localparam int S_BC  = 7;
    localparam int S_MC  = 8;

    localparam logic [2:0] NONE = 3'b000;
    localparam logic [2:0] BEQ  = 3'b001;
    localparam logic [2:0] BNE  = 3'b010;
    localparam logic [2:0] BLEZ = 3'b011;
    localparam logic [2:0] BGTZ = 3'b100;
    localparam logic [2:0] BLTZ = 3'b101;
    localparam logic [2:0] BGEZ = 3'b110;
    localparam logic [2:0] RSV  = 3'b111;

    logic                       clk = 1'b0;
    logic                       reset = 1'b1;
    logic [DATA_W-1:0]          if_pc = '0;
    logic                       pred_taken;
    logic [DATA_W-1:0]          pred_target;
    logic                       id_valid = 1'b0;
    logic                       id_stall = 1'b0;
    logic [DATA_W-1:0]          id_pc = '0;
    logic                       id_pred_taken = 1'b0;
    logic [2:0]                 branch_type = '0;
    logic [15:0]                id_imm = '0;
    logic [DATA_W-1:0]          reg_a = '0;
    logic [DATA_W-1:0]          reg_b = '0;
    logic [FWD_SRCS*DATA_W-1:0] fwd_data = '0;
    logic [SEL_W-1:0]           src_sel_a = '0;
    logic [SEL_W-1:0]           src_sel_b = '0;
    logic [DATA_W-1:0]          cmp_a;
    logic [DATA_W-1:0]          cmp_b;
    logic                       branch_taken;
    logic                       mispredict;
    logic [DATA_W-1:0]          redirect_pc;
`ifdef BRANCH_STATS_EN
    logic [31:0]                branch_cnt;
    logic [31:0]                mispredict_cnt;
`endif

    branch_predict_resolve #(
        .DATA_W   (DATA_W),
        .BHT_DEPTH(BHT_DEPTH),
        .FWD_SRCS (FWD_SRCS)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_pc        (if_pc),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .id_valid     (id_valid),
        .id_stall     (id_stall),
        .id_pc        (id_pc),
        .id_pred_taken(id_pred_taken),
        .branch_type  (branch_type),
        .id_imm       (id_imm),
        .reg_a        (reg_a),
        .reg_b        (reg_b),
        .fwd_data     (fwd_data),
        .src_sel_a    (src_sel_a),
        .src_sel_b    (src_sel_b),
        .cmp_a        (cmp_a),
        .cmp_b        (cmp_b),
        .branch_taken (branch_taken),
        .mispredict   (mispredict),
        .redirect_pc  (redirect_pc)
`ifdef BRANCH_STATS_EN
        ,
        .branch_cnt    (branch_cnt),
        .mispredict_cnt(mispredict_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int          sig;
        logic [31:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic logic [31:0] get_sig(input int s);
        case (s)
            S_PT:    return {31'd0, pred_taken};
            S_PTG:   return pred_target;
            S_MP:    return {31'd0, mispredict};
            S_RPC:   return redirect_pc;
            S_BT:    return {31'd0, branch_taken};
            S_CA:    return cmp_a;
            S_CB:    return cmp_b;
`ifdef BRANCH_STATS_EN
            S_BC:    return branch_cnt;
            S_MC:    return mispredict_cnt;
`endif
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    // Monitor: outputs are combinational, so every queued expectation is
    // checked against the settled outputs at the falling edge.
    logic [31:0] act;
    always @(negedge clk) begin
        while (sb.size() > 0) begin
            cur = sb.pop_front();
            act = get_sig(cur.sig);
            n_tests++;
            if (act !== cur.val) begin
                n_fail++;
                $display("FAIL %s: got %h want %h", cur.name, act, cur.val);
            end
        end
    end

    task automatic expect_v(input int s, input logic [31:0] v, input string n);
        exp_t e;
        e.sig  = s;
        e.val  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid      = 1'b0;
        id_stall      = 1'b0;
        id_pred_taken = 1'b0;
        branch_type   = NONE;
        src_sel_a     = '0;
        src_sel_b     = '0;
    endtask

    task automatic br(input logic [31:0] pc, input logic [2:0] t,
                      input logic [15:0] imm, input logic [31:0] a,
                      input logic [31:0] b, input logic p);
        id_valid      = 1'b1;
        id_stall      = 1'b0;
        id_pc         = pc;
        branch_type   = t;
        id_imm        = imm;
        reg_a         = a;
        reg_b         = b;
        id_pred_taken = p;
        src_sel_a     = '0;
        src_sel_b     = '0;
    endtask

    logic [2:0]  ct_t [13] = '{BNE, BNE, BGTZ, BGTZ, BGTZ, BLEZ, BLEZ,
                               BLEZ, BGEZ, BGEZ, BEQ, NONE, RSV};
    logic [31:0] ct_a [13] = '{32'd5, 32'd5, 32'd0, 32'd1, 32'h8000_0000,
                               32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0,
                               32'h8000_0000, 32'd1, 32'd5, 32'd5};
    logic [31:0] ct_b [13] = '{32'd5, 32'd6, 32'd0, 32'd0, 32'd0, 32'd0,
                               32'd0, 32'd0, 32'd0, 32'd0, 32'd2, 32'd5,
                               32'd5};
    logic        ct_e [13] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1,
                               1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

    initial begin
        idle();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Post-reset lookup
        if_pc = 32'h0040_0010;
        expect_v(S_PT, 32'd0, "rst_pred_taken");
        expect_v(S_PTG, 32'h0040_0014, "rst_pred_target");
        expect_v(S_MP, 32'd0, "rst_mispredict");
`ifdef BRANCH_STATS_EN
        expect_v(S_BC, 32'd0, "rst_branch_cnt");
        expect_v(S_MC, 32'd0, "rst_mispredict_cnt");
`endif

        // Taken beq, predicted not taken; lookup same cycle sees old entry
        cyc();
        br(32'h0040_0010, BEQ, 16'h0003, 32'd5, 32'd5, 1'b0);
        expect_v(S_BT, 32'd1, "beq_taken");
        expect_v(S_MP, 32'd1, "beq_mispredict");
        expect_v(S_RPC, 32'h0040_0020, "beq_redirect");
        expect_v(S_PT, 32'd0, "same_cycle_pre_update");

        cyc();
        idle();
        expect_v(S_PT, 32'd1, "learned_pred_taken");
        expect_v(S_PTG, 32'h0040_0020, "learned_pred_target");
        expect_v(S_MP, 32'd0, "idle_no_mispredict");

        // Same index, different tag
        cyc();
        if_pc = 32'h0040_0110;
        expect_v(S_PT, 32'd0, "alias_tag_miss");
        expect_v(S_PTG, 32'h0040_0114, "alias_target");

        // Forwarding
        cyc();
        fwd_data    = {32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0001};
        reg_a       = 32'd0;
        reg_b       = 32'd7;
        branch_type = BLTZ;
        src_sel_a   = 2'd2;
        src_sel_b   = 2'd1;
        expect_v(S_CA, 32'hFFFF_FFFF, "fwd_slot1_a");
        expect_v(S_CB, 32'h0000_0001, "fwd_slot0_b");
        expect_v(S_BT, 32'd1, "fwd_bltz_taken");

        cyc();
        reg_a     = 32'h0000_0010;
        src_sel_a = SEL_W'(FWD_SRCS + 1);
        src_sel_b = 2'd3;
        expect_v(S_CA, 32'h0000_0010, "sel_over_reg_a");
        expect_v(S_CB, 32'h1234_5678, "fwd_slot2_b");
        expect_v(S_BT, 32'd0, "bltz_pos_not_taken");

        // Condition table (not valid, resolve only)
        for (int i = 0; i < 13; i++) begin
            cyc();
            idle();
            branch_type = ct_t[i];
            reg_a       = ct_a[i];
            reg_b       = ct_b[i];
            expect_v(S_BT, {31'd0, ct_e[i]}, $sformatf("cond_%0d", i));
        end

        // Non-branch types never mispredict or update
        cyc();
        br(32'h0040_0300, RSV, 16'h0001, 32'd5, 32'd5, 1'b1);
        if_pc = 32'h0040_0300;
        expect_v(S_MP, 32'd0, "rsv_no_mispredict");
        cyc();
        branch_type = NONE;
        expect_v(S_MP, 32'd0, "none_no_mispredict");
        cyc();
        idle();
        expect_v(S_PT, 32'd0, "rsv_no_update");

        // Counter training at 0x00400100
        if_pc = 32'h0040_0100;
        for (int i = 0; i < 4; i++) begin
            cyc();
            br(32'h0040_0100, BEQ, 16'h0010, 32'd3, 32'd3, (i != 0));
            expect_v(S_PT, {31'd0, (i != 0)}, $sformatf("train_pt_%0d", i));
            expect_v(S_MP, {31'd0, (i == 0)}, $sformatf("train_mp_%0d", i));
            expect_v(S_RPC, 32'h0040_0144, $sformatf("train_rpc_%0d", i));
        end
        cyc();
        br(32'h0040_0100, BEQ, 16'h0010, 32'd1, 32'd2, 1'b1);
        expect_v(S_PT, 32'd1, "sat_pred_taken");
        expect_v(S_MP, 32'd1, "nt_mispredict");
        expect_v(S_RPC, 32'h0040_0104, "nt_redirect");
        cyc();
        idle();
        expect_v(S_PT, 32'd1, "ctr10_pred_taken");
        expect_v(S_PTG, 32'h0040_0144, "ctr10_pred_target");
        cyc();
        br(32'h0040_0100, BEQ, 16'h0010, 32'd1, 32'd2, 1'b1);
        expect_v(S_MP, 32'd1, "nt2_mispredict");
        cyc();
        idle();
        expect_v(S_PT, 32'd0, "ctr01_pred_taken");
        expect_v(S_PTG, 32'h0040_0104, "ctr01_pred_target");

        // Negative offset at top half, stalled and invalid
        cyc();
        br(32'h8000_0000, BEQ, 16'hFFFF, 32'd9, 32'd9, 1'b0);
        id_stall = 1'b1;
        if_pc    = 32'h8000_0000;
        expect_v(S_BT, 32'd1, "stall_taken");
        expect_v(S_RPC, 32'h8000_0000, "neg_target");
        expect_v(S_MP, 32'd0, "stall_no_mispredict");
        cyc();
        id_stall = 1'b0;
        id_valid = 1'b0;
        expect_v(S_MP, 32'd0, "invalid_no_mispredict");
        cyc();
        idle();
        expect_v(S_PT, 32'd0, "stall_no_update");
        expect_v(S_PTG, 32'h8000_0004, "stall_pred_target");

        // Target MSB pinned to the PC half
        cyc();
        branch_type = BEQ;
        id_pc       = 32'h7FFF_FFFC;
        id_imm      = 16'h0000;
        reg_a       = 32'd3;
        reg_b       = 32'd3;
        expect_v(S_RPC, 32'h0000_0000, "msb_forced");
`ifdef BRANCH_STATS_EN
        expect_v(S_BC, 32'd7, "branch_cnt");
        expect_v(S_MC, 32'd4, "mispredict_cnt");
`endif

        // Reset during a qualifying update
        cyc();
        br(32'h0040_0200, BEQ, 16'h0001, 32'd4, 32'd4, 1'b0);
        if_pc = 32'h0040_0200;
        #3;
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        idle();
        expect_v(S_PT, 32'd0, "rst_abort_pred");
        expect_v(S_PTG, 32'h0040_0204, "rst_abort_target");
`ifdef BRANCH_STATS_EN
        expect_v(S_BC, 32'd0, "rst_branch_cnt2");
        expect_v(S_MC, 32'd0, "rst_mispredict_cnt2");
`endif
        cyc();
        if_pc = 32'h0040_0010;
        expect_v(S_PT, 32'd0, "rst_cleared_entry");

        cyc();
        cyc();
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d left want 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
